// File: rtl/reg_dump_sequencer_pkg.sv
// rtl/reg_dump_sequencer_pkg.sv - shared debug frame definitions: state encoding, byte width, framing bytes
package reg_dump_sequencer_pkg;

   localparam int         BYTE_W          = 8;
   localparam logic [7:0] HEADER_DEFAULT  = 8'hA5;
   localparam logic [7:0] TRAILER_DEFAULT = 8'h5A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ADDR,
      ST_WAIT,
      ST_BYTES,
      ST_TRL,
      ST_DONE
   } dump_state_t;

endpackage

// File: rtl/reg_dump_sequencer.sv
// rtl/reg_dump_sequencer.sv - dumps the register bank to the UART TX FIFO as a framed byte stream
module reg_dump_sequencer
   import reg_dump_sequencer_pkg::*;
#(
   parameter int                NUM_REGS = 32,
   parameter logic [BYTE_W-1:0] HEADER   = HEADER_DEFAULT,
   parameter logic [BYTE_W-1:0] TRAILER  = TRAILER_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic [4:0]        readAddr,
   input  logic [31:0]       readData,
   input  logic              fifoFull,
   output logic [BYTE_W-1:0] fifoData,
   output logic              fifoWrite,
   output logic              busy,
   output logic              done
);

   localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

   dump_state_t state;
   logic [1:0]  byte_idx;
   logic [31:0] shreg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         readAddr  <= '0;
         fifoData  <= '0;
         fifoWrite <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         byte_idx  <= '0;
         shreg     <= '0;
      end else begin
         fifoWrite <= 1'b0;
         done      <= 1'b0;
         if (abort && state != ST_IDLE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     state    <= ST_HDR;
                     busy     <= 1'b1;
                     readAddr <= '0;
                  end
               end
               ST_HDR: begin
                  if (!fifoFull) begin
                     fifoData  <= HEADER;
                     fifoWrite <= 1'b1;
                     state     <= ST_ADDR;
                  end
               end
               // readAddr is already stable here; this cycle covers the bank latency
               ST_ADDR: state <= ST_WAIT;
               ST_WAIT: begin
                  shreg    <= readData;
                  byte_idx <= 2'd3;
                  state    <= ST_BYTES;
               end
               ST_BYTES: begin
                  if (!fifoFull) begin
                     fifoData  <= shreg[31:24];
                     fifoWrite <= 1'b1;
                     shreg     <= {shreg[23:0], 8'h00};
                     byte_idx  <= byte_idx - 2'd1;
                     if (byte_idx == 2'd0) begin
                        if (readAddr == LAST_ADDR) begin
                           state <= ST_TRL;
                        end else begin
                           readAddr <= readAddr + 5'd1;
                           state    <= ST_ADDR;
                        end
                     end
                  end
               end
               ST_TRL: begin
                  if (!fifoFull) begin
                     fifoData  <= TRAILER;
                     fifoWrite <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb/tb_reg_dump_sequencer.sv - directed self-checking bench for reg_dump_sequencer
module tb_reg_dump_sequencer;

   logic        clock = 1'b0;
   logic        reset, start, abort, fifoFull;
   logic [4:0]  readAddr;
   logic [31:0] readData;
   logic [7:0]  fifoData;
   logic        fifoWrite, busy, done;

   logic        start1, abort1, fifoFull1;
   logic [4:0]  readAddr1;
   logic [31:0] readData1;
   logic [7:0]  fifoData1;
   logic        fifoWrite1, busy1, done1;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] cap[$];
   logic [7:0] cap1[$];
   int  viol, done_cnt, done_cnt1;
   logic last_full;

   always #5 clock = ~clock;

   reg_dump_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .readAddr(readAddr), .readData(readData), .fifoFull(fifoFull),
      .fifoData(fifoData), .fifoWrite(fifoWrite), .busy(busy), .done(done)
   );

   reg_dump_sequencer #(.NUM_REGS(1)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .abort(abort1),
      .readAddr(readAddr1), .readData(readData1), .fifoFull(fifoFull1),
      .fifoData(fifoData1), .fifoWrite(fifoWrite1), .busy(busy1), .done(done1)
   );

   // bank model: one-cycle read latency
   always @(posedge clock) begin
      readData  <= 32'h01010101 * {27'd0, readAddr};
      readData1 <= 32'h01010101 * {27'd0, readAddr1};
   end

   // FIFO-side monitor, sampled mid-cycle
   always @(negedge clock) begin
      if (fifoWrite) cap.push_back(fifoData);
      if (fifoWrite && last_full) viol++;
      last_full = fifoFull;
      if (done) done_cnt++;
      if (fifoWrite1) cap1.push_back(fifoData1);
      if (done1) done_cnt1++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic verify_frame(input string tag, input int n_regs, input logic [7:0] q[$]);
      logic [7:0] exp;
      check({tag, "_len"}, q.size(), 4 * n_regs + 2);
      for (int i = 0; i < q.size() && i < 4 * n_regs + 2; i++) begin
         if (i == 0) exp = 8'hA5;
         else if (i == 4 * n_regs + 1) exp = 8'h5A;
         else exp = 8'((i - 1) / 4);
         check($sformatf("%s_byte%0d", tag, i), q[i], exp);
      end
   endtask

   task automatic launch();
      @(negedge clock);
      cap.delete();
      viol = 0;
      done_cnt = 0;
      last_full = 1'b0;
      start = 1'b1;
   endtask

   task automatic wait_done(input int limit, input bit rand_full, input bit repulse, output int n);
      n = 0;
      while (n < limit) begin
         @(posedge clock);
         n++;
         #1;
         start = repulse && (n == 5 || n == 40);
         if (rand_full) fifoFull = 1'($urandom_range(0, 1));
         if (done) break;
      end
      check("done_seen", done, 1'b1);
      fifoFull = 1'b0;
   endtask

   initial begin
      int n;
      int wr;
      int extra;
      reset = 1'b1; start = 1'b0; abort = 1'b0; fifoFull = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; fifoFull1 = 1'b0;
      viol = 0; done_cnt = 0; done_cnt1 = 0; last_full = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_readAddr", readAddr, 0);
      check("rst_fifoData", fifoData, 0);
      check("rst_fifoWrite", fifoWrite, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;

      // full frame, no back-pressure
      launch();
      wait_done(400, 1'b0, 1'b0, n);
      check("frame_done_cycle", n, 196);
      @(posedge clock); #1;
      check("frame_busy_after", busy, 0);
      check("frame_done_pulse", done, 0);
      verify_frame("frame", 32, cap);
      check("frame_done_cnt", done_cnt, 1);
      check("frame_viol", viol, 0);

      // random back-pressure
      launch();
      wait_done(3000, 1'b1, 1'b0, n);
      repeat (3) @(posedge clock);
      #1;
      verify_frame("bp", 32, cap);
      check("bp_done_cnt", done_cnt, 1);
      check("bp_viol", viol, 0);

      // abort during the third byte of register 7
      launch();
      wr = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (fifoWrite) wr++;
         if (wr == 31) break;
      end
      check("abort_reach", wr, 31);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_fifoWrite", fifoWrite, 0);
      extra = 0;
      repeat (20) begin
         @(posedge clock); #1;
         if (fifoWrite || busy) extra++;
      end
      check("abort_quiet", extra, 0);
      check("abort_bytes", cap.size(), 31);
      check("abort_last_byte", cap[cap.size() - 1], 8'h07);
      check("abort_no_done", done_cnt, 0);
      launch();
      wait_done(400, 1'b0, 1'b0, n);
      @(posedge clock); #1;
      verify_frame("after_abort", 32, cap);
      check("after_abort_done_cnt", done_cnt, 1);

      // start re-pulsed while busy
      launch();
      wait_done(400, 1'b0, 1'b1, n);
      check("repulse_done_cycle", n, 196);
      repeat (5) @(posedge clock);
      #1;
      check("repulse_idle", busy, 0);
      verify_frame("repulse", 32, cap);
      check("repulse_done_cnt", done_cnt, 1);

      // reset mid-BYTES
      launch();
      wr = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (fifoWrite) wr++;
         if (wr == 10) break;
      end
      check("midrst_reach", wr, 10);
      reset = 1'b1;
      @(posedge clock); #1;
      check("midrst_readAddr", readAddr, 0);
      check("midrst_fifoData", fifoData, 0);
      check("midrst_fifoWrite", fifoWrite, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("midrst_stays_idle", busy, 0);

      // NUM_REGS=1 build
      @(negedge clock);
      cap1.delete();
      done_cnt1 = 0;
      start1 = 1'b1;
      n = 0;
      while (n < 50) begin
         @(posedge clock);
         n++;
         #1;
         start1 = 1'b0;
         if (done1) break;
      end
      check("one_done_seen", done1, 1'b1);
      check("one_done_cycle", n, 10);
      @(posedge clock); #1;
      verify_frame("one", 1, cap1);
      check("one_done_cnt", done_cnt1, 1);
      check("one_busy_after", busy1, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
